caliptra_prim_resp_router: RTL and testbench
============================================

# caliptra_prim_resp_router

In-order 1:N response router forming the return path of the fixed-priority N:1 request arbiter. Each request the arbiter forwards downstream has its winning index recorded in a tracking FIFO. Responses from the single downstream channel come back in issue order. Each response is steered to the originating requester port through a registered output stage with per-port ready.

## Interface
Parameters:
- N, 8, number of requester ports (N >= 2)
- DW, 32, response data width
- Depth, 4, maximum outstanding requests tracked (Depth >= 1)
- IdxW, $clog2(N), derived (localparam), port index width
- CntW, $clog2(Depth+1), derived (localparam), occupancy counter width

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset; synchronous, active-high
- issue_valid_i  in  1  a request was forwarded downstream this cycle (arbiter valid & accepted)
- issue_idx_i  in  IdxW  index of the granted requester
- issue_ready_o  out  1  tracker can record an issue; upstream gates the arbiter's ready_i with it
- rsp_valid_i  in  1  downstream response valid
- rsp_data_i  in  DW  downstream response data
- rsp_ready_o  out  1  response accepted this cycle when high with rsp_valid_i
- valid_o  out  N  per-port response valid; at most one bit set
- data_o  out  DW  response data, shared by all ports
- ready_i  in  N  per-port response ready
- outstanding_o  out  CntW  number of tracked issues not yet answered

## Operation
- Tracking FIFO: Depth entries of IdxW bits, with read/write pointers and occupancy counter cnt.
  - Push on issue_valid_i & issue_ready_o.
  - Pop on rsp_valid_i & rsp_ready_o.
- issue_ready_o = (cnt < Depth). No pop-to-push bypass: when full, issue stalls even if a pop occurs the same cycle.
- issue_valid_i while issue_ready_o = 0 is dropped, with no state change. This is a protocol violation, flagged by assertion.
- Output register holds out_valid, out_idx, out_data.
  - valid_o = out_valid ? (1 << out_idx) : 0.
  - data_o = out_data.
- Output drain: out_fire = out_valid & ready_i[out_idx]. ready_i on non-addressed ports is ignored.
- rsp_ready_o = (cnt != 0) & (~out_valid | out_fire). The response is stalled, never dropped, when no issue is outstanding.
- On response accept:
  - out_data <= rsp_data_i
  - out_idx <= FIFO head
  - out_valid <= 1
  - the FIFO pops
- Else if out_fire: out_valid <= 0.
- No bypass from push to pop: an entry pushed in cycle t is poppable from cycle t+1.
- Occupancy:
  - Push with pop: cnt unchanged.
  - Push only: +1.
  - Pop only: -1.
- outstanding_o = cnt.
- Pointers wrap modulo Depth. Depth is not required to be a power of 2, so the wrap is an explicit compare to Depth-1.
- Once out_valid is high, out_idx and out_data must not change until out_fire.

## Timing
- Reset (rst_i high at a clock edge):
  - cnt, pointers = 0
  - out_valid = 0, out_idx = 0, out_data = 0
  - Hence valid_o = 0, data_o = 0, outstanding_o = 0, issue_ready_o = 1, rsp_ready_o = 0.
- Reset mid-operation discards all tracked entries and any held output. Responses arriving afterwards stall until new issues are pushed.
- Latency:
  - Response accepted in cycle t appears on valid_o/data_o in cycle t+1.
  - Full throughput of 1 response/cycle when the addressed ready_i stays high.
- Back-to-back responses to different ports: out_fire and the new accept happen in the same cycle; the output switches ports with no bubble.
- All outputs are combinational only from registers, except rsp_ready_o, which is combinational from ready_i.

## Test plan
- Reset, then idle: valid_o=0, data_o=0, outstanding_o=0, issue_ready_o=1, rsp_ready_o=0.
- Issue idx 3, 0, 5 on consecutive cycles, then responses 0xA, 0xB, 0xC with all ready_i high:
  - valid_o=0x08/data 0xA, then 0x01/0xB, then 0x20/0xC on consecutive cycles
  - outstanding_o steps 3 -> 0
- Depth=4, issue 4 times: issue_ready_o=0 and outstanding_o=4. A 5th issue alongside a response pop is not recorded; count ends at 3.
- Issue idx 2, hold ready_i[2]=0 for 5 cycles with further responses pending:
  - valid_o=0x04 and data stable
  - rsp_ready_o=0
  - after ready_i[2] rises, the next response issues with no bubble
- rsp_valid_i=1 with outstanding_o=0: rsp_ready_o stays 0 and nothing is routed. Issue idx 1: the response is accepted the next cycle and valid_o=0x02.
- rst_i asserted with 2 outstanding and out_valid=1: the next cycle has all outputs at reset values and the old entries are never routed.

Source files
------------

// File: rtl/caliptra_prim_resp_router.sv
// ----------------------------------------------------------------------------
// caliptra_prim_resp_router
// In-order 1:N response router: tracks granted indices and steers responses.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module caliptra_prim_resp_router #(
  parameter int N     = 8,
  parameter int DW    = 32,
  parameter int Depth = 4,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1,
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  input  logic [IdxW-1:0] issue_idx_i,
  output logic            issue_ready_o,
  input  logic            rsp_valid_i,
  input  logic [DW-1:0]   rsp_data_i,
  output logic            rsp_ready_o,
  output logic [N-1:0]    valid_o,
  output logic [DW-1:0]   data_o,
  input  logic [N-1:0]    ready_i,
  output logic [CntW-1:0] outstanding_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LAST_PTR = PtrW'(Depth - 1);

  logic [IdxW-1:0] mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [IdxW-1:0] out_idx_q, out_idx_d;
  logic [DW-1:0]   out_data_q, out_data_d;

  logic push, pop, out_fire;

  assign issue_ready_o = (cnt_q < CntW'(Depth));
  assign push          = issue_valid_i & issue_ready_o;
  assign out_fire      = out_valid_q & ready_i[out_idx_q];
  assign rsp_ready_o   = (cnt_q != '0) & (~out_valid_q | out_fire);
  assign pop           = rsp_valid_i & rsp_ready_o;

  assign valid_o       = out_valid_q ? (N'(1) << out_idx_q) : '0;
  assign data_o        = out_data_q;
  assign outstanding_o = cnt_q;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;

    if (push) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
    end

    // A new accept reloads the output stage in the same cycle the old one drains.
    if (pop) begin
      rptr_d      = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
      out_valid_d = 1'b1;
      out_idx_d   = mem_q[rptr_q];
      out_data_d  = rsp_data_i;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
    end
  end

  // Entry storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= issue_idx_i;
    end
  end

`ifndef SYNTHESIS
  a_issue_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(issue_valid_i && !issue_ready_o))
    else $warning("issue dropped: tracker full");

  a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_q && !out_fire) |=> ($stable(out_idx_q) && $stable(out_data_q)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_caliptra_prim_resp_router.sv
// ----------------------------------------------------------------------------
// tb_caliptra_prim_resp_router
// Directed vector table plus randomized run against a queue-based model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_caliptra_prim_resp_router;

  localparam int N     = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [2:0]    issue_idx;
  logic          issue_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_ready;
  logic [N-1:0]  valid;
  logic [DW-1:0] data;
  logic [N-1:0]  ready;
  logic [2:0]    outstanding;

  always #5 clk = ~clk;

  caliptra_prim_resp_router #(.N(N), .DW(DW), .Depth(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .issue_valid_i(issue_valid),
    .issue_idx_i  (issue_idx),
    .issue_ready_o(issue_ready),
    .rsp_valid_i  (rsp_valid),
    .rsp_data_i   (rsp_data),
    .rsp_ready_o  (rsp_ready),
    .valid_o      (valid),
    .data_o       (data),
    .ready_i      (ready),
    .outstanding_o(outstanding)
  );

  typedef struct {
    logic          rst;
    logic          iv;
    logic [2:0]    idx;
    logic          rv;
    logic [DW-1:0] d;
    logic [N-1:0]  rdy;
    logic          chk;
    logic [N-1:0]  ev;
    logic [DW-1:0] ed;
    logic [2:0]    eo;
    logic          eir;
    logic          err;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad   = 0;

  // Reference model: list of pending port indices and a held output slot.
  int            m_q[$];
  bit            m_valid;
  int            m_idx;
  logic [DW-1:0] m_data;

  task automatic add(input logic r, input logic iv, input int idx, input logic rv,
                     input logic [DW-1:0] d, input logic [N-1:0] rdy, input logic chk,
                     input logic [N-1:0] ev, input logic [DW-1:0] ed, input int eo,
                     input logic eir, input logic err);
    vec_t v;
    v.rst = r; v.iv = iv; v.idx = 3'(idx); v.rv = rv; v.d = d; v.rdy = rdy;
    v.chk = chk; v.ev = ev; v.ed = ed; v.eo = 3'(eo); v.eir = eir; v.err = err;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input vec_t v);
    bit accept, fire, push;
    if (v.rst) begin
      m_q.delete();
      m_valid = 1'b0;
      m_idx   = 0;
      m_data  = '0;
    end else begin
      fire   = m_valid && v.rdy[m_idx];
      accept = v.rv && (m_q.size() > 0) && (!m_valid || fire);
      push   = v.iv && (m_q.size() < DEPTH);
      if (accept) begin
        m_idx   = m_q.pop_front();
        m_data  = v.d;
        m_valid = 1'b1;
      end else if (fire) begin
        m_valid = 1'b0;
      end
      if (push) m_q.push_back(int'(v.idx));
    end
  endtask

  task automatic step(input vec_t v, input bit use_model);
    logic [N-1:0]  ev;
    logic [DW-1:0] ed;
    logic [2:0]    eo;
    logic          eir, err;
    @(negedge clk);
    rst = v.rst; issue_valid = v.iv; issue_idx = v.idx;
    rsp_valid = v.rv; rsp_data = v.d; ready = v.rdy;
    #1;
    if (use_model) begin
      ev  = m_valid ? (N'(1) << m_idx) : '0;
      ed  = m_data;
      eo  = 3'(m_q.size());
      eir = (m_q.size() < DEPTH);
      err = (m_q.size() != 0) && (!m_valid || v.rdy[m_idx]);
    end else begin
      ev = v.ev; ed = v.ed; eo = v.eo; eir = v.eir; err = v.err;
    end
    if (use_model || v.chk) begin
      check("valid_o",       64'(valid),       64'(ev));
      check("data_o",        64'(data),        64'(ed));
      check("outstanding_o", 64'(outstanding), 64'(eo));
      check("issue_ready_o", 64'(issue_ready), 64'(eir));
      check("rsp_ready_o",   64'(rsp_ready),   64'(err));
    end
    @(posedge clk);
    model_step(v);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; issue_valid = 1'b0; issue_idx = '0;
    rsp_valid = 1'b0; rsp_data = '0; ready = '0;
    m_valid = 1'b0; m_idx = 0; m_data = '0;

    //   rst iv idx rv data   ready  chk ev     ed     eo ir rr
    add(1, 0, 0, 0, 32'h0,  8'hFF, 0, 8'h00, 32'h0,  0, 1, 0);
    add(0, 0, 0, 0, 32'h0,  8'hFF, 1, 8'h00, 32'h0,  0, 1, 0);
    // in-order routing of three issues
    add(0, 1, 3, 0, 32'h0,  8'hFF, 1, 8'h00, 32'h0,  0, 1, 0);
    add(0, 1, 0, 0, 32'h0,  8'hFF, 1, 8'h00, 32'h0,  1, 1, 1);
    add(0, 1, 5, 0, 32'h0,  8'hFF, 1, 8'h00, 32'h0,  2, 1, 1);
    add(0, 0, 0, 1, 32'hA,  8'hFF, 1, 8'h00, 32'h0,  3, 1, 1);
    add(0, 0, 0, 1, 32'hB,  8'hFF, 1, 8'h08, 32'hA,  2, 1, 1);
    add(0, 0, 0, 1, 32'hC,  8'hFF, 1, 8'h01, 32'hB,  1, 1, 1);
    add(0, 0, 0, 0, 32'h0,  8'hFF, 1, 8'h20, 32'hC,  0, 1, 0);
    add(0, 0, 0, 0, 32'h0,  8'hFF, 1, 8'h00, 32'hC,  0, 1, 0);
    // fill to Depth, then a 5th issue alongside a pop is dropped
    add(0, 1, 1, 0, 32'h0,  8'hFF, 1, 8'h00, 32'hC,  0, 1, 0);
    add(0, 1, 2, 0, 32'h0,  8'hFF, 1, 8'h00, 32'hC,  1, 1, 1);
    add(0, 1, 4, 0, 32'h0,  8'hFF, 1, 8'h00, 32'hC,  2, 1, 1);
    add(0, 1, 6, 0, 32'h0,  8'hFF, 1, 8'h00, 32'hC,  3, 1, 1);
    add(0, 1, 7, 1, 32'hD,  8'hFF, 1, 8'h00, 32'hC,  4, 0, 1);
    add(0, 0, 0, 0, 32'h0,  8'hFF, 1, 8'h02, 32'hD,  3, 1, 1);
    // port 2 back-pressure for 5 cycles, then no-bubble drain
    add(0, 0, 0, 1, 32'hE,  8'hFF, 1, 8'h00, 32'hD,  3, 1, 1);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 1, 32'hF, 8'hFB, 1, 8'h04, 32'hE, 2, 1, 0);
    add(0, 0, 0, 1, 32'hF,  8'hFF, 1, 8'h04, 32'hE,  2, 1, 1);
    add(0, 0, 0, 1, 32'h10, 8'hFF, 1, 8'h10, 32'hF,  1, 1, 1);
    // response with nothing outstanding stalls until an issue arrives
    add(0, 0, 0, 1, 32'h11, 8'hFF, 1, 8'h40, 32'h10, 0, 1, 0);
    add(0, 1, 1, 1, 32'h11, 8'hFF, 1, 8'h00, 32'h10, 0, 1, 0);
    add(0, 0, 0, 1, 32'h11, 8'hFF, 1, 8'h00, 32'h10, 1, 1, 1);
    add(0, 0, 0, 0, 32'h0,  8'hFF, 1, 8'h02, 32'h11, 0, 1, 0);
    // reset with two outstanding and a held output
    add(0, 1, 3, 0, 32'h0,  8'h00, 1, 8'h00, 32'h11, 0, 1, 0);
    add(0, 1, 5, 1, 32'h22, 8'h00, 1, 8'h00, 32'h11, 1, 1, 1);
    add(0, 1, 6, 0, 32'h0,  8'h00, 1, 8'h08, 32'h22, 1, 1, 0);
    add(1, 0, 0, 1, 32'h33, 8'h00, 1, 8'h08, 32'h22, 2, 1, 0);
    add(0, 0, 0, 1, 32'h44, 8'hFF, 1, 8'h00, 32'h0,  0, 1, 0);
    add(0, 0, 0, 1, 32'h44, 8'hFF, 1, 8'h00, 32'h0,  0, 1, 0);

    foreach (vq[i]) step(vq[i], 1'b0);

    // Randomized phase; the model has tracked every cycle so far.
    for (int c = 0; c < 1500; c++) begin
      v.rst = ($urandom_range(99, 0) == 0);
      v.iv  = ($urandom_range(1, 0) == 1) && (m_q.size() < DEPTH);
      v.idx = 3'($urandom_range(7, 0));
      v.rv  = ($urandom_range(9, 0) < 6);
      v.d   = $urandom;
      for (int b = 0; b < N; b++) v.rdy[b] = ($urandom_range(9, 0) < 7);
      v.chk = 1'b0; v.ev = '0; v.ed = '0; v.eo = '0; v.eir = 1'b0; v.err = 1'b0;
      step(v, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
